// File: rtl/board_io_pkg.sv
// Shared board-I/O definitions: debounce FSM state codes and a ms-to-cycles helper
// for sizing timing parameters at the top level.
package board_io_pkg;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ARM_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] ARM_RELEASE = 2'd3;

  // Whole-kHz clocks assumed; widened so 1 s at 50 MHz does not overflow mid-calculation.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    longint unsigned cycles;
    cycles = (64'(clk_hz) / 64'd1000) * 64'(ms);
    return 32'(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Key-side signal bundle: raw pin in, debounced level and event strobes out.
interface button_debounce_if;

  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic toggle;

  // Board/user side: drives the pin, consumes the events.
  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, toggle
  );

  // Debouncer side.
  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, toggle
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; reset value chosen per pin
// so reset looks like the pin's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronised, polarity-normalised key turned into a clean
// level plus press/release/long-press strobes and a press-toggled level.
module button_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(50_000_000, 20),
  parameter int unsigned LONG_CYCLES     = ms_to_cycles(50_000_000, 1000),
  parameter logic        ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  button_debounce_if.slave  bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);

  logic            sync_pin;
  logic            pressed;
  logic [1:0]      state,    state_nxt;
  logic [DB_W-1:0] db_cnt,   db_cnt_nxt;
  logic [LG_W-1:0] long_cnt, long_cnt_nxt;
  logic            level_q,   level_nxt;
  logic            press_q,   press_nxt;
  logic            release_q, release_nxt;
  logic            long_q,    long_nxt;
  logic            toggle_q,  toggle_nxt;

  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_in),
    .q     (sync_pin)
  );

  assign pressed = sync_pin ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      long_cnt  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      long_cnt  <= long_cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      long_q    <= long_nxt;
      toggle_q  <= toggle_nxt;
    end
  end

  // db_cnt holds the stable cycles already seen; the current cycle completes the
  // window when it equals DEBOUNCE_CYCLES-1, so the strobe lands DEBOUNCE_CYCLES after arming.
  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    long_cnt_nxt = long_cnt;
    level_nxt    = level_q;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    toggle_nxt   = toggle_q;

    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt  = ARM_PRESS;
          db_cnt_nxt = DB_W'(1);
        end
      end
      ARM_PRESS: begin
        if (!pressed) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          press_nxt  = 1'b1;
          level_nxt  = 1'b1;
          toggle_nxt = ~toggle_q;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt  = ARM_RELEASE;
          db_cnt_nxt = DB_W'(1);
        end
      end
      ARM_RELEASE: begin
        if (pressed) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          db_cnt_nxt  = '0;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase

    // Long-press timer: restarts on each accepted press, saturates so it strobes once.
    if (press_nxt) begin
      long_cnt_nxt = '0;
    end else if (((state == HELD) || (state == ARM_RELEASE)) && (long_cnt != LG_MAX)) begin
      long_cnt_nxt = long_cnt + LG_W'(1);
      long_nxt     = (long_cnt == LG_LAST);
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.toggle        = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce against a run-length reference model.
module tb_button_debounce;

  localparam int unsigned DB = 8;
  localparam int unsigned LG = 40;

  logic clk;
  logic rst_n;

  button_debounce_if bif();

  button_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pressed key is seen two clock edges late; a level change is
  // accepted once the seen value has differed from the level for DB consecutive cycles.
  logic pin_q[$];
  logic run_val;
  int   run_len;
  int   held;
  logic e_level, e_press, e_release, e_long, e_toggle;

  task automatic model_reset();
    pin_q     = {1'b0, 1'b0};
    run_val   = 1'b0;
    run_len   = 0;
    held      = 0;
    e_level   = 1'b0;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
    e_toggle  = 1'b0;
  endtask

  task automatic model_step(input logic pin);
    logic v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    v = pin_q[pin_q.size() - 2];
    if (v == run_val) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_val = v;
      run_len = 1;
    end
    if (e_level && held < int'(LG) + 1) held++;
    e_long    = e_level && (held == int'(LG));
    e_press   = !e_level && run_val && (run_len >= int'(DB));
    e_release = e_level && !run_val && (run_len >= int'(DB));
    if (e_press) begin
      e_level  = 1'b1;
      e_toggle = ~e_toggle;
      held     = 0;
    end
    if (e_release) e_level = 1'b0;
    pin_q.push_back(~pin);
    pin_q.delete(0);
  endtask

  int cyc = 0;
  int n_press, n_release, n_long;
  int press_cyc, release_cyc, long_cyc;

  function automatic logic [4:0] outs();
    return {bif.btn_level, bif.press_pulse, bif.release_pulse, bif.long_pulse, bif.toggle};
  endfunction

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_long = 0;
    press_cyc = -1000; release_cyc = -1000; long_cyc = -1000;
  endtask

  // One clock: drive at negedge, model at posedge, compare #1 later, return at negedge.
  task automatic tick(input logic pin);
    bif.btn_in = pin;
    @(posedge clk);
    cyc++;
    model_step(pin);
    #1;
    check("cycle_outs", 32'(outs()), 32'({e_level, e_press, e_release, e_long, e_toggle}));
    if (bif.press_pulse)   begin n_press++;   press_cyc   = cyc; end
    if (bif.release_pulse) begin n_release++; release_cyc = cyc; end
    if (bif.long_pulse)    begin n_long++;    long_cyc    = cyc; end
    @(negedge clk);
  endtask

  int t0;

  initial begin
    rst_n      = 1'b0;
    bif.btn_in = 1'b1;
    model_reset();
    clear_counts();
    @(negedge clk);
    repeat (3) tick(1'b1);
    rst_n = 1'b1;

    // Idle key: nothing happens
    repeat (100) tick(1'b1);
    check("t1_outs", 32'(outs()), 32'd0);
    check("t1_events", 32'(n_press + n_release + n_long), 32'd0);

    // Clean press
    clear_counts();
    t0 = cyc;
    repeat (12) tick(1'b0);
    check("t2_press_lat", 32'(press_cyc - t0), 32'd10);
    check("t2_press_cnt", 32'(n_press), 32'd1);
    check("t2_level", 32'(bif.btn_level), 32'd1);
    check("t2_toggle", 32'(bif.toggle), 32'd1);

    // Long hold, then release
    repeat (58) tick(1'b0);
    check("t4_long_lat", 32'(long_cyc - press_cyc), 32'd40);
    check("t4_long_cnt", 32'(n_long), 32'd1);
    t0 = cyc;
    repeat (12) tick(1'b1);
    check("t4_release_lat", 32'(release_cyc - t0), 32'd10);
    check("t4_level", 32'(bif.btn_level), 32'd0);
    check("t4_toggle", 32'(bif.toggle), 32'd1);

    // Bouncy press
    clear_counts();
    for (int b = 0; b < 5; b++) begin
      repeat (3) tick(1'b0);
      repeat (3) tick(1'b1);
    end
    t0 = cyc;
    repeat (14) tick(1'b0);
    check("t3_press_cnt", 32'(n_press), 32'd1);
    check("t3_press_lat", 32'(press_cyc - t0), 32'd10);
    repeat (14) tick(1'b1);

    // Two short presses
    clear_counts();
    repeat (2) begin
      repeat (20) tick(1'b0);
      repeat (20) tick(1'b1);
    end
    check("t5_press_cnt", 32'(n_press), 32'd2);
    check("t5_release_cnt", 32'(n_release), 32'd2);
    check("t5_long_cnt", 32'(n_long), 32'd0);
    check("t5_toggle", 32'(bif.toggle), 32'd0);

    // Reset while held, key stays down
    clear_counts();
    repeat (15) tick(1'b0);
    check("t6_pre_press", 32'(n_press), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    clear_counts();
    t0 = cyc;
    repeat (14) tick(1'b0);
    check("t6_press_lat", 32'(press_cyc - t0), 32'd10);
    check("t6_press_cnt", 32'(n_press), 32'd1);
    repeat (14) tick(1'b1);

    // Random bounce / hold segments
    for (int s = 0; s < 200; s++) begin
      logic p;
      int   len;
      p   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 55)) : int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) tick(p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
